mod_execute_mc: RTL and testbench

- Parametrised, multi-cycle successor to the pipeline's execute ALU; sits between the MEM/EX register and writeback.
- Takes one operation per handshake (opcode class, two operands, tag); returns result, high-half result, tag and a full arithmetic flag vector.
- Single-cycle ALU/shift ops issue at one per clock.
- Multiplies (and optional divides) run on an internal iterative datapath with back-pressure.

---
 rtl/mod_execute_mc_if.sv | 35 +++
 rtl/mod_execute_mc.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mod_execute_mc.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mod_execute_mc_if.sv
// Operation/result handshake bundle for mod_execute_mc.
// The master side offers operations and consumes results; the slave side
// is the execute unit.
interface mod_execute_mc_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_result_hi;
    logic [TAG_W-1:0]  out_tag;
    logic              out_wr_en;
    logic [4:0]        out_flags;
    logic              out_flags_we;
    logic              out_err;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_result_hi, out_tag,
               out_wr_en, out_flags, out_flags_we, out_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_result_hi, out_tag,
               out_wr_en, out_flags, out_flags_we, out_err
    );
endinterface

// File: rtl/mod_execute_mc.sv
// Multi-cycle execute unit: single-cycle ALU/shift ops at one per clock,
// iterative MUL/IMUL (MUL_STEP multiplier bits per cycle) with back-pressure.
// Optional feature macro: EXEC_DIV_EN enables op 13 as an unsigned restoring
// divide (1 bit/cycle); without it op 13 is illegal.
// Flags are {OF,SF,ZF,PF,CF}.
module mod_execute_mc #(
    parameter int DATA_W   = 64,
    parameter int TAG_W    = 4,
    parameter int MUL_STEP = 1
) (
    input logic             clk,
    input logic             reset,
    mod_execute_mc_if.slave bus
);
    localparam int LG = $clog2(DATA_W);
    localparam int M  = DATA_W - 1;
    localparam logic [LG-1:0] MUL_LAST = LG'(DATA_W / MUL_STEP - 1);
`ifdef EXEC_DIV_EN
    localparam logic [LG-1:0] DIV_LAST = LG'(DATA_W - 1);
`endif

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB  = 4'd1,  OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3,  OP_XOR  = 4'd4,  OP_CMP = 4'd5;
    localparam logic [3:0] OP_TST = 4'd6,  OP_SHL  = 4'd7,  OP_SHR = 4'd8;
    localparam logic [3:0] OP_SAR = 4'd9,  OP_MUL  = 4'd10, OP_IMUL = 4'd11;
    localparam logic [3:0] OP_MOVB = 4'd12;
`ifdef EXEC_DIV_EN
    localparam logic [3:0] OP_DIV = 4'd13;
`endif

    localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_HOLD = 2'd2;

    function automatic logic [4:0] f_flags(input logic of, input logic cf,
                                           input logic [DATA_W-1:0] r);
        return {of, r[M], (r == '0), ~^r[7:0], cf};
    endfunction

    // control / output registers
    logic [1:0]          r_state;
    logic [LG-1:0]       r_cnt;
    logic                r_out_valid, r_wr_en, r_flags_we, r_err;
    logic [DATA_W-1:0]   r_result, r_result_hi;
    logic [TAG_W-1:0]    r_tag;
    logic [4:0]          r_flags;
    // iterative datapath registers
    logic [2*DATA_W-1:0] r_prod;
    logic [DATA_W-1:0]   r_mcand;
    logic                r_neg, r_signed;
`ifdef EXEC_DIV_EN
    logic                r_is_div;
`endif

    logic w_in_ready, w_accept;
    assign w_in_ready = !reset && (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // single-cycle datapath
    logic [DATA_W:0]        w_sum, w_diff, w_shl, w_shr;
    logic signed [DATA_W:0] w_sar_s;
    logic [LG-1:0]          w_cnt;
    logic [DATA_W-1:0]      w_res, w_mag_a, w_mag_b;
    logic                   w_cf, w_of, w_wr_en, w_flags_we, w_err, w_iter, w_imul;

    assign w_sum   = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign w_diff  = {1'b0, bus.in_a} - {1'b0, bus.in_b};
    assign w_cnt   = bus.in_b[LG-1:0];
    assign w_shl   = {1'b0, bus.in_a} << w_cnt;
    assign w_shr   = {bus.in_a, 1'b0} >> w_cnt;
    assign w_sar_s = $signed({bus.in_a, 1'b0}) >>> w_cnt;
    assign w_imul  = (bus.in_op == OP_IMUL);
    assign w_mag_a = (w_imul && bus.in_a[M]) ? -bus.in_a : bus.in_a;
    assign w_mag_b = (w_imul && bus.in_b[M]) ? -bus.in_b : bus.in_b;

    // opcode decode and single-cycle result/flag computation
    always_comb begin
        w_res      = '0;
        w_cf       = 1'b0;
        w_of       = 1'b0;
        w_wr_en    = 1'b1;
        w_flags_we = 1'b1;
        w_err      = 1'b0;
        w_iter     = 1'b0;
        case (bus.in_op)
            OP_ADD: begin
                w_res = w_sum[M:0];
                w_cf  = w_sum[DATA_W];
                w_of  = (bus.in_a[M] == bus.in_b[M]) && (w_sum[M] != bus.in_a[M]);
            end
            OP_SUB, OP_CMP: begin
                w_res   = w_diff[M:0];
                w_cf    = w_diff[DATA_W];
                w_of    = (bus.in_a[M] != bus.in_b[M]) && (w_diff[M] != bus.in_a[M]);
                w_wr_en = (bus.in_op == OP_SUB);
            end
            OP_AND: w_res = bus.in_a & bus.in_b;
            OP_OR:  w_res = bus.in_a | bus.in_b;
            OP_XOR: w_res = bus.in_a ^ bus.in_b;
            OP_TST: begin
                w_res   = bus.in_a & bus.in_b;
                w_wr_en = 1'b0;
            end
            OP_SHL: begin
                w_res      = w_shl[M:0];
                w_cf       = (w_cnt != '0) && w_shl[DATA_W];
                w_of       = (w_cnt == LG'(1)) && (w_shl[M] ^ w_shl[DATA_W]);
                w_flags_we = (w_cnt != '0);
            end
            OP_SHR: begin
                w_res      = w_shr[DATA_W:1];
                w_cf       = (w_cnt != '0) && w_shr[0];
                w_of       = (w_cnt == LG'(1)) && bus.in_a[M];
                w_flags_we = (w_cnt != '0);
            end
            OP_SAR: begin
                w_res      = w_sar_s[DATA_W:1];
                w_cf       = (w_cnt != '0) && w_sar_s[0];
                w_flags_we = (w_cnt != '0);
            end
            OP_MUL, OP_IMUL: w_iter = 1'b1;
            OP_MOVB: begin
                w_res      = bus.in_b;
                w_flags_we = 1'b0;
            end
`ifdef EXEC_DIV_EN
            OP_DIV: begin
                if (bus.in_b == '0) begin
                    w_err      = 1'b1;
                    w_wr_en    = 1'b0;
                    w_flags_we = 1'b0;
                end else begin
                    w_iter = 1'b1;
                end
            end
`endif
            default: begin
                w_err      = 1'b1;
                w_wr_en    = 1'b0;
                w_flags_we = 1'b0;
            end
        endcase
    end

    // iterative step: shift-add multiply on {hi, multiplier}, optional restoring divide
    logic [DATA_W+MUL_STEP-1:0]   w_pp, w_msum;
    logic [2*DATA_W+MUL_STEP-1:0] w_mcat;
    logic [2*DATA_W-1:0]          w_mnext, w_mfin, w_step, w_fin;
    logic [LG-1:0]                w_last;
    logic [DATA_W-1:0]            w_it_lo, w_it_hi;
    logic                         w_it_ovf, w_it_flags_we;

    assign w_pp    = {{MUL_STEP{1'b0}}, r_mcand} * {{DATA_W{1'b0}}, r_prod[MUL_STEP-1:0]};
    assign w_msum  = {{MUL_STEP{1'b0}}, r_prod[2*DATA_W-1:DATA_W]} + w_pp;
    assign w_mcat  = {w_msum, r_prod[DATA_W-1:0]};
    assign w_mnext = (2*DATA_W)'(w_mcat >> MUL_STEP);
    assign w_mfin  = r_neg ? -w_mnext : w_mnext;

`ifdef EXEC_DIV_EN
    logic [DATA_W:0]     w_rsh, w_dtry;
    logic                w_qbit;
    logic [2*DATA_W-1:0] w_dnext;
    assign w_rsh         = r_prod[2*DATA_W-1:DATA_W-1];
    assign w_dtry        = w_rsh - {1'b0, r_mcand};
    assign w_qbit        = !w_dtry[DATA_W];
    assign w_dnext       = {(w_qbit ? w_dtry[M:0] : w_rsh[M:0]), r_prod[DATA_W-2:0], w_qbit};
    assign w_step        = r_is_div ? w_dnext : w_mnext;
    assign w_fin         = r_is_div ? w_dnext : w_mfin;
    assign w_last        = r_is_div ? DIV_LAST : MUL_LAST;
    assign w_it_flags_we = !r_is_div;
`else
    assign w_step        = w_mnext;
    assign w_fin         = w_mfin;
    assign w_last        = MUL_LAST;
    assign w_it_flags_we = 1'b1;
`endif

    assign w_it_lo  = w_fin[DATA_W-1:0];
    assign w_it_hi  = w_fin[2*DATA_W-1:DATA_W];
    assign w_it_ovf = r_signed ? (w_it_hi != {DATA_W{w_it_lo[M]}}) : (w_it_hi != '0);

    // FSM, output registers and handshake bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_tag       <= '0;
            r_wr_en     <= 1'b0;
            r_flags     <= '0;
            r_flags_we  <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept && !w_iter) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_result_hi <= '0;
            r_tag       <= bus.in_tag;
            r_wr_en     <= w_wr_en;
            r_flags     <= w_flags_we ? f_flags(w_of, w_cf, w_res) : 5'd0;
            r_flags_we  <= w_flags_we;
            r_err       <= w_err;
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
            r_state     <= S_BUSY;
            r_cnt       <= '0;
            r_tag       <= bus.in_tag;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + LG'(1);
            if (r_cnt == w_last) begin
                r_state     <= S_HOLD;
                r_out_valid <= 1'b1;
                r_result    <= w_it_lo;
                r_result_hi <= w_it_hi;
                r_wr_en     <= 1'b1;
                r_flags     <= w_it_flags_we ? f_flags(w_it_ovf, w_it_ovf, w_it_lo) : 5'd0;
                r_flags_we  <= w_it_flags_we;
                r_err       <= 1'b0;
            end
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
        end
    end

    // iterative operand load on accept, one step per BUSY cycle
    always_ff @(posedge clk) begin
        if (w_accept && w_iter) begin
`ifdef EXEC_DIV_EN
            r_is_div <= (bus.in_op == OP_DIV);
            if (bus.in_op == OP_DIV) begin
                r_prod   <= {{DATA_W{1'b0}}, bus.in_a};
                r_mcand  <= bus.in_b;
                r_neg    <= 1'b0;
                r_signed <= 1'b0;
            end else begin
                r_prod   <= {{DATA_W{1'b0}}, w_mag_b};
                r_mcand  <= w_mag_a;
                r_neg    <= w_imul && (bus.in_a[M] ^ bus.in_b[M]);
                r_signed <= w_imul;
            end
`else
            r_prod   <= {{DATA_W{1'b0}}, w_mag_b};
            r_mcand  <= w_mag_a;
            r_neg    <= w_imul && (bus.in_a[M] ^ bus.in_b[M]);
            r_signed <= w_imul;
`endif
        end else if (r_state == S_BUSY) begin
            r_prod <= w_step;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_result    = r_result;
    assign bus.out_result_hi = r_result_hi;
    assign bus.out_tag       = r_tag;
    assign bus.out_wr_en     = r_wr_en;
    assign bus.out_flags     = r_flags;
    assign bus.out_flags_we  = r_flags_we;
    assign bus.out_err       = r_err;
endmodule

// File: tb/tb_mod_execute_mc.sv
// Directed bench for mod_execute_mc (DATA_W=64, MUL_STEP=1).
// Follows EXEC_DIV_EN to choose the divide checks.
module tb_mod_execute_mc;
    localparam int DW = 64;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mod_execute_mc_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    mod_execute_mc #(.DATA_W(DW), .TAG_W(TW), .MUL_STEP(1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string t, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", t, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] tg);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tg;
    endtask

    task automatic chk_out(input string t, input logic [63:0] res, input logic [63:0] hi,
                           input logic [3:0] tg, input logic wr, input logic [4:0] fl,
                           input logic fwe, input logic er);
        chk({t, ".valid"},    bus.out_valid,     1'b1);
        chk({t, ".result"},   bus.out_result,    res);
        chk({t, ".hi"},       bus.out_result_hi, hi);
        chk({t, ".tag"},      bus.out_tag,       tg);
        chk({t, ".wr_en"},    bus.out_wr_en,     wr);
        chk({t, ".flags"},    bus.out_flags,     fl);
        chk({t, ".flags_we"}, bus.out_flags_we,  fwe);
        chk({t, ".err"},      bus.out_err,       er);
    endtask

    // wait (bounded) for out_valid; returns edges waited and in_ready-high count
    task automatic wait_valid(output int cycles, output int ir_high);
        cycles  = 0;
        ir_high = 0;
        while (!bus.out_valid && cycles < 200) begin
            if (bus.in_ready) ir_high++;
            step();
            cycles++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, irh, nv;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 4'd0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst.in_ready",  bus.in_ready,   1'b0);
        chk("rst.out_valid", bus.out_valid,  1'b0);
        chk("rst.result",    bus.out_result, 64'd0);
        chk("rst.flags",     bus.out_flags,  5'd0);
        chk("rst.err",       bus.out_err,    1'b0);
        chk("rst.wr_en",     bus.out_wr_en,  1'b0);
        reset = 1'b0;
        #1;
        chk("post_rst.in_ready", bus.in_ready, 1'b1);

        // ADD wraps to zero
        bus.out_ready = 1'b1;
        offer(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd1);
        step();
        chk_out("add", 64'd0, 64'd0, 4'd1, 1'b1, 5'b00111, 1'b1, 1'b0);

        // SUB accepted while ADD drains, then stall
        offer(4'd1, 64'd5, 64'd7, 4'd2);
        step();
        bus.out_ready = 1'b0;
        offer(4'd5, 64'd3, 64'd3, 4'd3);
        #1;
        chk_out("sub", 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 4'd2, 1'b1, 5'b01001, 1'b1, 1'b0);
        chk("sub.stall_in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.valid",    bus.out_valid,  1'b1);
            chk("stall.result",   bus.out_result, 64'hFFFF_FFFF_FFFF_FFFE);
            chk("stall.tag",      bus.out_tag,    4'd2);
            chk("stall.in_ready", bus.in_ready,   1'b0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("unstall.in_ready", bus.in_ready, 1'b1);
        step();
        offer(4'd4, 64'hF0, 64'h0F, 4'd4);
        chk_out("cmp", 64'd0, 64'd0, 4'd3, 1'b0, 5'b00110, 1'b1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk_out("xor", 64'hFF, 64'd0, 4'd4, 1'b1, 5'b00010, 1'b1, 1'b0);
        step();
        chk("drain.valid", bus.out_valid, 1'b0);

        // IMUL -3 * 2^62
        offer(4'd11, 64'hFFFF_FFFF_FFFF_FFFD, 64'h4000_0000_0000_0000, 4'd5);
        step();
        bus.in_valid = 1'b0;
        wait_valid(cyc, irh);
        chk("imul.latency",       cyc, 64);
        chk("imul.in_ready_high", irh, 0);
        chk_out("imul", 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5,
                1'b1, 5'b10011, 1'b1, 1'b0);
        chk("imul.hold_in_ready", bus.in_ready, 1'b0);
        step();
        chk("imul.done_valid", bus.out_valid, 1'b0);
        chk("imul.idle_ready", bus.in_ready,  1'b1);

        // unsigned MUL with result held under back-pressure
        bus.out_ready = 1'b0;
        offer(4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd6);
        step();
        bus.in_valid = 1'b0;
        wait_valid(cyc, irh);
        chk("mul.latency", cyc, 64);
        step();
        step();
        chk_out("mul", 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 4'd6, 1'b1, 5'b11001, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk("mul.done_valid", bus.out_valid, 1'b0);

        // shifts, MOVB, illegal, op 13 by zero
        offer(4'd7, 64'h8000_0000_0000_0001, 64'd1, 4'd7);
        step();
        offer(4'd9, 64'h8000_0000_0000_0000, 64'd65, 4'd8);
        chk_out("shl1", 64'd2, 64'd0, 4'd7, 1'b1, 5'b10001, 1'b1, 1'b0);
        step();
        offer(4'd7, 64'h1234, 64'd64, 4'd9);
        chk_out("sar65", 64'hC000_0000_0000_0000, 64'd0, 4'd8, 1'b1, 5'b01010, 1'b1, 1'b0);
        step();
        offer(4'd8, 64'h8000_0000_0000_0003, 64'd1, 4'd10);
        chk("shl0.result",   bus.out_result,   64'h1234);
        chk("shl0.flags_we", bus.out_flags_we, 1'b0);
        chk("shl0.tag",      bus.out_tag,      4'd9);
        step();
        offer(4'd12, 64'd1, 64'h55, 4'd11);
        chk_out("shr1", 64'h4000_0000_0000_0001, 64'd0, 4'd10, 1'b1, 5'b10001, 1'b1, 1'b0);
        step();
        offer(4'd14, 64'd9, 64'd9, 4'd12);
        chk("movb.result",   bus.out_result,   64'h55);
        chk("movb.flags_we", bus.out_flags_we, 1'b0);
        chk("movb.wr_en",    bus.out_wr_en,    1'b1);
        step();
        offer(4'd13, 64'd5, 64'd0, 4'd13);
        chk_out("illegal", 64'd0, 64'd0, 4'd12, 1'b0, 5'd0, 1'b0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk_out("op13_b0", 64'd0, 64'd0, 4'd13, 1'b0, 5'd0, 1'b0, 1'b1);
        step();

`ifdef EXEC_DIV_EN
        offer(4'd13, 64'd100, 64'd7, 4'd14);
        step();
        bus.in_valid = 1'b0;
        wait_valid(cyc, irh);
        chk("div.latency",       cyc, 64);
        chk("div.in_ready_high", irh, 0);
        chk_out("div", 64'd14, 64'd2, 4'd14, 1'b1, 5'd0, 1'b0, 1'b0);
        step();
`else
        offer(4'd13, 64'd100, 64'd7, 4'd14);
        step();
        bus.in_valid = 1'b0;
        chk_out("op13_illegal", 64'd0, 64'd0, 4'd14, 1'b0, 5'd0, 1'b0, 1'b1);
        step();
`endif

        // reset 10 cycles into a MUL discards it
        offer(4'd10, 64'd3, 64'd5, 4'd15);
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("abort.valid",    bus.out_valid, 1'b0);
        chk("abort.in_ready", bus.in_ready,  1'b1);
        nv = 0;
        repeat (70) begin
            step();
            if (bus.out_valid) nv++;
        end
        chk("abort.no_output", nv, 0);
        offer(4'd0, 64'd2, 64'd3, 4'd1);
        step();
        bus.in_valid = 1'b0;
        chk_out("after_abort", 64'd5, 64'd0, 4'd1, 1'b1, 5'b00010, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
